// File: rtl/pipe_skid_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_skid_stage_if
//  Description : One valid/ready channel carrying a control field and a
//                payload. The stage consumes one as its upstream port (slave)
//                and drives one as its downstream port (master).
//  Signals     : valid  - producer has an item
//                ready  - consumer can accept; transfer when valid & ready
//                ctrl   - CTRL_W control bits
//                data   - DATA_W payload
//  Revision    : 1.0  initial release
// ============================================================================
interface pipe_skid_stage_if #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 192
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    // Producer side of the channel
    modport master (
        output valid,
        output ctrl,
        output data,
        input  ready
    );

    // Consumer side of the channel
    modport slave (
        input  valid,
        input  ctrl,
        input  data,
        output ready
    );
endinterface
`default_nettype wire

// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_skid_stage
//  Description : Elastic pipeline register with a 2-entry skid buffer.
//                Full throughput, in_ready decoded from registered state only,
//                control bits forced to zero whenever no entry is held.
//  Ports       : clk        - rising-edge clock
//                reset      - synchronous active-high reset
//                flush      - drop all held entries and this cycle's input
//                up         - upstream channel (in_valid/in_ready/in_ctrl/in_data)
//                dn         - downstream channel (out_valid/out_ready/out_ctrl/out_data)
//                occupancy  - number of entries held (0..2)
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_skid_stage #(
    parameter int CTRL_W    = 16,
    parameter int DATA_W    = 192,
    parameter bit ZERO_DATA = 1'b1
) (
    input  wire logic           clk,
    input  wire logic           reset,
    input  wire logic           flush,
    pipe_skid_stage_if.slave    up,
    pipe_skid_stage_if.master   dn,
    output logic [1:0]          occupancy
);

    // State encodes occupancy directly so the occupancy port is a plain copy.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [CTRL_W-1:0]  r_main_ctrl;
    logic [DATA_W-1:0]  r_main_data;
    logic [CTRL_W-1:0]  r_skid_ctrl;
    logic [DATA_W-1:0]  r_skid_data;

    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_in_fire;
    logic               w_out_fire;
    logic               w_load_main_in;
    logic               w_load_skid_in;
    logic               w_load_main_skid;

    // Handshake outputs come from the state register only, so there is no
    // combinational path from out_ready or in_valid to in_ready.
    assign w_in_ready  = (r_state != ST_FULL);
    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_in_fire   = up.valid & w_in_ready;
    assign w_out_fire  = w_out_valid & dn.ready;

    assign up.ready    = w_in_ready;
    assign dn.valid    = w_out_valid;
    // Gating keeps stale or undefined control bits from leaking as a bubble.
    assign dn.ctrl     = w_out_valid ? r_main_ctrl : '0;
    assign dn.data     = r_main_data;
    assign occupancy   = r_state;

    // ------------------------------------------------------------------
    // Next-state and entry load selection
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_skid_in   = 1'b0;
        w_load_main_skid = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_load_main_in = 1'b1;
                    w_state_nxt    = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    // Pass-through: new item replaces the one leaving.
                    w_load_main_in = 1'b1;
                end else if (w_in_fire) begin
                    w_load_skid_in = 1'b1;
                    w_state_nxt    = ST_FULL;
                end else if (w_out_fire) begin
                    w_state_nxt    = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only a pop can happen.
                if (w_out_fire) begin
                    w_load_main_skid = 1'b1;
                    w_state_nxt      = ST_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register: reset beats flush beats handshake
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else if (flush) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Entry storage. Payload is always cleared on reset; on flush it is
    // cleared only when ZERO_DATA is set, otherwise it keeps its value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else if (flush) begin
            r_main_ctrl <= '0;
            r_skid_ctrl <= '0;
            if (ZERO_DATA) begin
                r_main_data <= '0;
                r_skid_data <= '0;
            end
        end else begin
            if (w_load_main_in) begin
                r_main_ctrl <= up.ctrl;
                r_main_data <= up.data;
            end else if (w_load_main_skid) begin
                r_main_ctrl <= r_skid_ctrl;
                r_main_data <= r_skid_data;
            end
            if (w_load_skid_in) begin
                r_skid_ctrl <= up.ctrl;
                r_skid_data <= up.data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_skid_stage
//  Description : Self-checking bench for pipe_skid_stage. A queue-based
//                reference model (capacity-2 FIFO) predicts every output.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_skid_stage;

    localparam int CTRL_W    = 16;
    localparam int DATA_W    = 192;
    localparam bit ZERO_DATA = 1'b1;

    typedef struct packed {
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
    } item_t;

    logic clk;
    logic reset;
    logic flush;
    logic [1:0] occupancy;

    pipe_skid_stage_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) up_if ();
    pipe_skid_stage_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dn_if ();

    pipe_skid_stage #(
        .CTRL_W    (CTRL_W),
        .DATA_W    (DATA_W),
        .ZERO_DATA (ZERO_DATA)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .up        (up_if.slave),
        .dn        (dn_if.master),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_pass   = 0;
    item_t q[$];

    // Drive one cycle of inputs, advance the reference FIFO, then settle
    // to 1 time unit after the rising edge for sampling.
    task automatic cycle(input bit rs, input bit fl, input bit iv,
                         input logic [CTRL_W-1:0] ic, input logic [DATA_W-1:0] id,
                         input bit ordy);
        bit inf;
        bit outf;
        reset        = rs;
        flush        = fl;
        up_if.valid  = iv;
        up_if.ctrl   = ic;
        up_if.data   = id;
        dn_if.ready  = ordy;
        inf  = iv && (q.size() < 2);
        outf = (q.size() > 0) && ordy;
        @(posedge clk);
        if (rs || fl) begin
            q.delete();
        end else begin
            if (outf) void'(q.pop_front());
            if (inf) q.push_back('{c: ic, d: id});
        end
        #1;
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] v;
        for (int k = 0; k < DATA_W / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic test_reset();
        cycle(1, 0, 0, '0, '0, 0);
        cycle(1, 0, 0, '0, '0, 0);
        cycle(0, 0, 0, '0, '0, 0);
        n_checks++;
        if (dn_if.valid !== 1'b0 || dn_if.ctrl !== '0 || dn_if.data !== '0 ||
            up_if.ready !== 1'b1 || occupancy !== 2'd0)
            $display("FAIL reset: valid=%b ctrl=%h data_zero=%b ready=%b occ=%0d, need 0/0/1/1/0",
                     dn_if.valid, dn_if.ctrl, (dn_if.data == '0), up_if.ready, occupancy);
        else n_pass++;
    endtask

    task automatic test_stream();
        for (int k = 1; k <= 8; k++) begin
            cycle(0, 0, 1, CTRL_W'(k), DATA_W'(32'h100 + k - 1), 1);
            n_checks++;
            if (dn_if.valid !== 1'b1 || dn_if.ctrl !== CTRL_W'(k) ||
                dn_if.data !== DATA_W'(32'h100 + k - 1) || occupancy !== 2'd1 || up_if.ready !== 1'b1)
                $display("FAIL stream[%0d]: valid=%b ctrl=%h data=%h occ=%0d ready=%b, need 1/%h/%h/1/1",
                         k, dn_if.valid, dn_if.ctrl, dn_if.data[31:0], occupancy, up_if.ready,
                         k, 32'h100 + k - 1);
            else n_pass++;
        end
        cycle(0, 0, 0, '0, '0, 1);
        n_checks++;
        if (dn_if.valid !== 1'b0 || dn_if.ctrl !== '0 || occupancy !== 2'd0)
            $display("FAIL stream_drain: valid=%b ctrl=%h occ=%0d, need 0/0/0",
                     dn_if.valid, dn_if.ctrl, occupancy);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        cycle(0, 0, 1, 16'h000A, DATA_W'(32'hAAA), 0);
        cycle(0, 0, 1, 16'h000B, DATA_W'(32'hBBB), 0);
        n_checks++;
        if (occupancy !== 2'd2 || up_if.ready !== 1'b0 || dn_if.ctrl !== 16'h000A ||
            dn_if.data !== DATA_W'(32'hAAA))
            $display("FAIL bp_full: occ=%0d ready=%b ctrl=%h data=%h, need 2/0/000a/aaa",
                     occupancy, up_if.ready, dn_if.ctrl, dn_if.data[31:0]);
        else n_pass++;
        cycle(0, 0, 1, 16'h000C, DATA_W'(32'hCCC), 0);
        n_checks++;
        if (occupancy !== 2'd2 || dn_if.ctrl !== 16'h000A || dn_if.data !== DATA_W'(32'hAAA))
            $display("FAIL bp_ignore_c: occ=%0d ctrl=%h data=%h, need 2/000a/aaa",
                     occupancy, dn_if.ctrl, dn_if.data[31:0]);
        else n_pass++;
        cycle(0, 0, 0, 16'h000C, DATA_W'(32'hCCC), 1);
        n_checks++;
        if (dn_if.valid !== 1'b1 || dn_if.ctrl !== 16'h000B || dn_if.data !== DATA_W'(32'hBBB) ||
            occupancy !== 2'd1 || up_if.ready !== 1'b1)
            $display("FAIL bp_pop_a: valid=%b ctrl=%h data=%h occ=%0d ready=%b, need 1/000b/bbb/1/1",
                     dn_if.valid, dn_if.ctrl, dn_if.data[31:0], occupancy, up_if.ready);
        else n_pass++;
        cycle(0, 0, 0, '0, '0, 1);
        n_checks++;
        if (dn_if.valid !== 1'b0 || dn_if.ctrl !== '0 || occupancy !== 2'd0)
            $display("FAIL bp_empty: valid=%b ctrl=%h occ=%0d, need 0/0/0",
                     dn_if.valid, dn_if.ctrl, occupancy);
        else n_pass++;
    endtask

    task automatic test_flush();
        logic [DATA_W-1:0] exp_d;
        cycle(0, 0, 1, 16'h00A1, DATA_W'(32'h1A1), 0);
        cycle(0, 0, 1, 16'h00B2, DATA_W'(32'h2B2), 0);
        cycle(0, 1, 1, 16'h00C3, DATA_W'(32'h3C3), 1);
        exp_d = ZERO_DATA ? '0 : DATA_W'(32'h1A1);
        n_checks++;
        if (occupancy !== 2'd0 || dn_if.valid !== 1'b0 || dn_if.ctrl !== '0 ||
            dn_if.data !== exp_d || up_if.ready !== 1'b1)
            $display("FAIL flush: occ=%0d valid=%b ctrl=%h data=%h ready=%b, need 0/0/0/%h/1",
                     occupancy, dn_if.valid, dn_if.ctrl, dn_if.data[31:0], up_if.ready, exp_d[31:0]);
        else n_pass++;
    endtask

    task automatic test_reset_full();
        cycle(0, 0, 1, 16'h0055, DATA_W'(32'h555), 0);
        cycle(0, 0, 1, 16'h0066, DATA_W'(32'h666), 0);
        cycle(1, 0, 1, 16'h0077, DATA_W'(32'h777), 0);
        n_checks++;
        if (occupancy !== 2'd0 || dn_if.valid !== 1'b0 || dn_if.ctrl !== '0 ||
            dn_if.data !== '0 || up_if.ready !== 1'b1)
            $display("FAIL reset_full: occ=%0d valid=%b ctrl=%h data=%h ready=%b, need 0/0/0/0/1",
                     occupancy, dn_if.valid, dn_if.ctrl, dn_if.data[31:0], up_if.ready);
        else n_pass++;
        // Skid entry must also have been cleared: refill and drain through it.
        cycle(0, 0, 1, 16'h0088, DATA_W'(32'h888), 0);
        cycle(0, 0, 1, 16'h0099, DATA_W'(32'h999), 0);
        cycle(0, 0, 0, '0, '0, 1);
        n_checks++;
        if (dn_if.ctrl !== 16'h0099 || dn_if.data !== DATA_W'(32'h999))
            $display("FAIL reset_refill: ctrl=%h data=%h, need 0099/999",
                     dn_if.ctrl, dn_if.data[31:0]);
        else n_pass++;
        cycle(0, 0, 0, '0, '0, 1);
    endtask

    task automatic test_random();
        int errs = 0;
        int pops = 0;
        for (int n = 0; n < 10000; n++) begin
            bit iv;
            bit ordy;
            bit fl;
            logic [CTRL_W-1:0] ic;
            logic [DATA_W-1:0] id;
            iv   = ($urandom_range(0, 99) < 60);
            ordy = ($urandom_range(0, 99) < 55);
            fl   = ($urandom_range(0, 255) == 0);
            ic   = CTRL_W'($urandom);
            id   = rand_data();
            if (q.size() > 0 && ordy && !fl) pops++;
            cycle(0, fl, iv, ic, id, ordy);
            n_checks++;
            if (occupancy !== 2'(q.size()) || up_if.ready !== (q.size() < 2) ||
                dn_if.valid !== (q.size() > 0) ||
                (q.size() == 0 && dn_if.ctrl !== '0) ||
                (q.size() > 0 && (dn_if.ctrl !== q[0].c || dn_if.data !== q[0].d))) begin
                errs++;
                if (errs <= 10)
                    $display("FAIL random[%0d]: occ=%0d valid=%b ready=%b ctrl=%h, need occ=%0d ctrl=%h",
                             n, occupancy, dn_if.valid, up_if.ready, dn_if.ctrl, q.size(),
                             (q.size() > 0) ? q[0].c : '0);
            end else n_pass++;
        end
        n_checks++;
        if (pops < 1000)
            $display("FAIL random_activity: pops=%0d, need >= 1000", pops);
        else n_pass++;
    endtask

    initial begin
        reset       = 1'b1;
        flush       = 1'b0;
        up_if.valid = 1'b0;
        up_if.ctrl  = '0;
        up_if.data  = '0;
        dn_if.ready = 1'b0;
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_reset_full();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
